antares_bus_demux_1_2: RTL and testbench

Single-master to two-slave bus demultiplexer with registered request path, address-based slave selection, and a per-transaction timeout. Sits between the core's data-memory port and two slaves: slave 0 is the default region (RAM), slave 1 is a mask/base-matched region (I/O). It latches each request, drives it to exactly one slave, and returns that slave's ready and read data. If the slave never answers, it terminates the access with an error.

---
 rtl/antares_bus_pkg.sv | 16 +
 rtl/antares_bus_demux_1_2_if.sv | 24 ++
 rtl/antares_bus_timeout.sv | 40 ++++
 rtl/antares_bus_demux_1_2.sv | 158 +++++++++++++++
 tb/tb_antares_bus_demux_1_2.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/antares_bus_pkg.sv
// Shared definitions for the antares bus bridges: FSM encoding and region/timeout defaults.
package antares_bus_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } bus_state_e;

  localparam logic [31:0] S1_BASE_DEFAULT = 32'h1000_0000;
  localparam logic [31:0] S1_MASK_DEFAULT = 32'hF000_0000;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Width of the per-transaction timeout counter.
  localparam int unsigned TIMEOUT_CNT_WIDTH = 8;

endpackage

// File: rtl/antares_bus_demux_1_2_if.sv
// Simple request/ready bus: the master issues address/data/strobes, the slave answers with
// read data, a one-cycle ready and an error flag qualified by ready.
interface antares_bus_demux_1_2_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr;
  logic                    rd;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    ready;
  logic                    error;

  modport master (
    output address, wr_data, wr, rd,
    input  rd_data, ready, error
  );

  modport slave (
    input  address, wr_data, wr, rd,
    output rd_data, ready, error
  );
endinterface

// File: rtl/antares_bus_timeout.sv
// Saturating busy-cycle counter; hit_o flags the last cycle allowed before a timeout.
module antares_bus_timeout
  import antares_bus_pkg::*;
#(
  parameter int unsigned Timeout = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic hit_o
);

  localparam logic [TIMEOUT_CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [TIMEOUT_CNT_WIDTH-1:0] HitVal = TIMEOUT_CNT_WIDTH'(Timeout - 1);

  logic [TIMEOUT_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Clear wins over count; counting stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == HitVal);

endmodule

// File: rtl/antares_bus_demux_1_2.sv
// One master to two slaves. Requests are latched into the selected slave's output registers;
// slave 1 is the mask/base-matched region, slave 0 everything else. A stuck access is
// terminated with an error after TIMEOUT busy cycles.
module antares_bus_demux_1_2
  import antares_bus_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE    = ADDR_WIDTH'(S1_BASE_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] S1_MASK    = ADDR_WIDTH'(S1_MASK_DEFAULT),
  parameter int unsigned           TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  antares_bus_demux_1_2_if.slave  m_bus,
  antares_bus_demux_1_2_if.master s0_bus,
  antares_bus_demux_1_2_if.master s1_bus
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  bus_state_e state_q, state_d;
  logic       sel_q, sel_d;

  logic [ADDR_WIDTH-1:0] s0_addr_q, s0_addr_d, s1_addr_q, s1_addr_d;
  logic [DATA_WIDTH-1:0] s0_data_q, s0_data_d, s1_data_q, s1_data_d;
  logic [StrbWidth-1:0]  s0_wr_q, s0_wr_d, s1_wr_q, s1_wr_d;
  logic                  s0_rd_q, s0_rd_d, s1_rd_q, s1_rd_d;

  logic req, hit, accept, busy, sel_ready, to_hit, done;

  assign req       = m_bus.rd | (|m_bus.wr);
  assign hit       = ((m_bus.address & S1_MASK) == S1_BASE);
  assign busy      = (state_q == StBusy);
  assign accept    = (state_q == StIdle) & req;
  // Only the selected slave's ready counts; the other one is ignored entirely.
  assign sel_ready = sel_q ? s1_bus.ready : s0_bus.ready;
  assign done      = busy & (sel_ready | to_hit);

  antares_bus_timeout #(
    .Timeout(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept),
    .enable_i(busy),
    .hit_o   (to_hit)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req)  state_d = StBusy;
      StBusy:  if (done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Master response; ready beats timeout when both land in the same cycle.
  always_comb begin
    m_bus.ready   = 1'b0;
    m_bus.error   = 1'b0;
    m_bus.rd_data = '0;
    unique case (state_q)
      StBusy: begin
        if (sel_ready) begin
          m_bus.ready   = 1'b1;
          m_bus.rd_data = sel_q ? s1_bus.rd_data : s0_bus.rd_data;
        end else if (to_hit) begin
          m_bus.ready = 1'b1;
          m_bus.error = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Request latching: load the chosen slave on accept, drop its strobes on completion.
  // The unselected slave keeps its last address/data and has idle strobes.
  always_comb begin
    sel_d     = sel_q;
    s0_addr_d = s0_addr_q;
    s0_data_d = s0_data_q;
    s0_wr_d   = s0_wr_q;
    s0_rd_d   = s0_rd_q;
    s1_addr_d = s1_addr_q;
    s1_data_d = s1_data_q;
    s1_wr_d   = s1_wr_q;
    s1_rd_d   = s1_rd_q;
    if (accept) begin
      sel_d = hit;
      if (hit) begin
        s1_addr_d = m_bus.address;
        s1_data_d = m_bus.wr_data;
        s1_wr_d   = m_bus.wr;
        s1_rd_d   = m_bus.rd;
      end else begin
        s0_addr_d = m_bus.address;
        s0_data_d = m_bus.wr_data;
        s0_wr_d   = m_bus.wr;
        s0_rd_d   = m_bus.rd;
      end
    end else if (done) begin
      if (sel_q) begin
        s1_wr_d = '0;
        s1_rd_d = 1'b0;
      end else begin
        s0_wr_d = '0;
        s0_rd_d = 1'b0;
      end
    end
  end

  // Request path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 1'b0;
      s0_addr_q <= '0;
      s0_data_q <= '0;
      s0_wr_q   <= '0;
      s0_rd_q   <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
      s1_wr_q   <= '0;
      s1_rd_q   <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      s0_addr_q <= s0_addr_d;
      s0_data_q <= s0_data_d;
      s0_wr_q   <= s0_wr_d;
      s0_rd_q   <= s0_rd_d;
      s1_addr_q <= s1_addr_d;
      s1_data_q <= s1_data_d;
      s1_wr_q   <= s1_wr_d;
      s1_rd_q   <= s1_rd_d;
    end
  end

  assign s0_bus.address = s0_addr_q;
  assign s0_bus.wr_data = s0_data_q;
  assign s0_bus.wr      = s0_wr_q;
  assign s0_bus.rd      = s0_rd_q;
  assign s1_bus.address = s1_addr_q;
  assign s1_bus.wr_data = s1_data_q;
  assign s1_bus.wr      = s1_wr_q;
  assign s1_bus.rd      = s1_rd_q;

endmodule

// File: tb/tb_antares_bus_demux_1_2.sv
// Directed bench for the 1:2 bus demux, built with TIMEOUT=8.
module tb_antares_bus_demux_1_2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  antares_bus_demux_1_2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();
  antares_bus_demux_1_2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0_if ();
  antares_bus_demux_1_2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1_if ();

  antares_bus_demux_1_2 #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .S1_BASE   (32'h1000_0000),
    .S1_MASK   (32'hF000_0000),
    .TIMEOUT   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m_bus (m_if),
    .s0_bus(s0_if),
    .s1_bus(s1_if)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_master();
    m_if.address = '0;
    m_if.wr_data = '0;
    m_if.wr      = '0;
    m_if.rd      = 1'b0;
  endtask

  initial begin
    idle_master();
    s0_if.rd_data = '0;
    s0_if.ready   = 1'b0;
    s0_if.error   = 1'b0;
    s1_if.rd_data = '0;
    s1_if.ready   = 1'b0;
    s1_if.error   = 1'b0;

    // Reset state
    advance();
    advance();
    settle();
    check_eq("rst_m_ready", m_if.ready, 0);
    check_eq("rst_m_error", m_if.error, 0);
    check_eq("rst_m_rd_data", m_if.rd_data, 0);
    check_eq("rst_s0_rd", s0_if.rd, 0);
    check_eq("rst_s1_wr", s1_if.wr, 0);
    advance();
    rst_n = 1'b1;
    advance();

    // Ready in IDLE is ignored
    s0_if.ready = 1'b1;
    s1_if.ready = 1'b1;
    settle();
    check_eq("idle_ready_ignored", m_if.ready, 0);
    advance();
    s0_if.ready = 1'b0;
    s1_if.ready = 1'b0;

    // Read to slave 0, ready two cycles after strobe
    m_if.address = 32'h0000_0100;
    m_if.rd      = 1'b1;
    advance();
    settle();
    check_eq("rd0_c1_s0_rd", s0_if.rd, 1);
    check_eq("rd0_c1_s0_addr", s0_if.address, 32'h0000_0100);
    check_eq("rd0_c1_s1_rd", s1_if.rd, 0);
    check_eq("rd0_c1_m_ready", m_if.ready, 0);
    advance();
    settle();
    check_eq("rd0_c2_m_ready", m_if.ready, 0);
    advance();
    s0_if.ready   = 1'b1;
    s0_if.rd_data = 32'hDEAD_BEEF;
    settle();
    check_eq("rd0_c3_m_ready", m_if.ready, 1);
    check_eq("rd0_c3_m_rd_data", m_if.rd_data, 32'hDEAD_BEEF);
    check_eq("rd0_c3_m_error", m_if.error, 0);
    check_eq("rd0_c3_s1_rd", s1_if.rd, 0);
    advance();
    idle_master();
    s0_if.ready = 1'b0;
    settle();
    check_eq("rd0_after_m_ready", m_if.ready, 0);
    check_eq("rd0_after_s0_rd", s0_if.rd, 0);

    // Write to slave 1; master fields change mid-BUSY without effect
    advance();
    m_if.address = 32'h1000_0004;
    m_if.wr      = 4'b0011;
    m_if.wr_data = 32'h1234_5678;
    advance();
    m_if.address = 32'h0000_0000;
    m_if.wr_data = 32'hFFFF_FFFF;
    settle();
    check_eq("wr1_c1_s1_wr", s1_if.wr, 4'b0011);
    check_eq("wr1_c1_s1_wr_data", s1_if.wr_data, 32'h1234_5678);
    check_eq("wr1_c1_s1_addr", s1_if.address, 32'h1000_0004);
    check_eq("wr1_c1_s0_wr", s0_if.wr, 0);
    check_eq("wr1_c1_s0_addr_hold", s0_if.address, 32'h0000_0100);
    advance();
    s1_if.ready = 1'b1;
    settle();
    check_eq("wr1_c2_s1_wr", s1_if.wr, 4'b0011);
    check_eq("wr1_c2_s1_wr_data", s1_if.wr_data, 32'h1234_5678);
    check_eq("wr1_c2_s0_wr", s0_if.wr, 0);
    check_eq("wr1_c2_m_ready", m_if.ready, 1);
    check_eq("wr1_c2_m_error", m_if.error, 0);
    advance();
    idle_master();
    s1_if.ready = 1'b0;
    settle();
    check_eq("wr1_after_s1_wr", s1_if.wr, 0);
    check_eq("wr1_after_m_ready", m_if.ready, 0);

    // Timeout on slave 1 after 8 BUSY cycles
    advance();
    m_if.address  = 32'h1000_0008;
    m_if.rd       = 1'b1;
    s1_if.rd_data = 32'hCAFE_F00D;
    for (int i = 1; i <= 8; i++) begin
      advance();
      settle();
      check_eq($sformatf("to_c%0d_m_ready", i), m_if.ready, (i == 8) ? 1 : 0);
      check_eq($sformatf("to_c%0d_s1_rd", i), s1_if.rd, 1);
    end
    check_eq("to_m_error", m_if.error, 1);
    check_eq("to_m_rd_data", m_if.rd_data, 0);
    advance();
    idle_master();
    settle();
    check_eq("to_after_s1_rd", s1_if.rd, 0);
    check_eq("to_after_m_ready", m_if.ready, 0);

    // Ready coincides with the timeout cycle: ready wins
    advance();
    m_if.address  = 32'h1000_0010;
    m_if.rd       = 1'b1;
    s1_if.rd_data = 32'h5A5A_A5A5;
    for (int i = 1; i <= 7; i++) begin
      advance();
      settle();
      check_eq($sformatf("tr_c%0d_m_ready", i), m_if.ready, 0);
    end
    advance();
    s1_if.ready = 1'b1;
    settle();
    check_eq("tr_m_ready", m_if.ready, 1);
    check_eq("tr_m_error", m_if.error, 0);
    check_eq("tr_m_rd_data", m_if.rd_data, 32'h5A5A_A5A5);
    advance();
    idle_master();
    s1_if.ready = 1'b0;
    settle();
    check_eq("tr_after_s1_rd", s1_if.rd, 0);

    // Wrong-slave ready ignored, then back-to-back request
    advance();
    m_if.address = 32'h0000_0200;
    m_if.rd      = 1'b1;
    advance();
    s1_if.ready   = 1'b1;
    s1_if.rd_data = 32'h0000_0BAD;
    settle();
    check_eq("wrong_ready_m_ready", m_if.ready, 0);
    advance();
    s1_if.ready   = 1'b0;
    s0_if.ready   = 1'b1;
    s0_if.rd_data = 32'h1111_2222;
    settle();
    check_eq("b2b_first_m_ready", m_if.ready, 1);
    check_eq("b2b_first_m_rd_data", m_if.rd_data, 32'h1111_2222);
    advance();
    s0_if.ready  = 1'b0;
    m_if.rd      = 1'b0;
    m_if.address = 32'h1000_0020;
    m_if.wr      = 4'hF;
    m_if.wr_data = 32'hA5A5_5A5A;
    settle();
    check_eq("b2b_idle_m_ready", m_if.ready, 0);
    check_eq("b2b_idle_s0_rd", s0_if.rd, 0);
    check_eq("b2b_idle_s1_wr", s1_if.wr, 0);
    advance();
    settle();
    check_eq("b2b_second_s1_wr", s1_if.wr, 4'hF);
    check_eq("b2b_second_s1_addr", s1_if.address, 32'h1000_0020);
    advance();
    s1_if.ready = 1'b1;
    settle();
    check_eq("b2b_second_m_ready", m_if.ready, 1);
    advance();
    idle_master();
    s1_if.ready = 1'b0;
    settle();
    check_eq("b2b_second_after_s1_wr", s1_if.wr, 0);

    // Reset in the middle of a BUSY access
    advance();
    m_if.address = 32'h0000_0300;
    m_if.rd      = 1'b1;
    advance();
    settle();
    check_eq("rstbusy_pre_s0_rd", s0_if.rd, 1);
    s0_if.ready = 1'b1;
    rst_n       = 1'b0;
    #1;
    check_eq("rstbusy_s0_rd", s0_if.rd, 0);
    check_eq("rstbusy_s1_wr", s1_if.wr, 0);
    check_eq("rstbusy_m_ready", m_if.ready, 0);
    idle_master();
    advance();
    s0_if.ready = 1'b0;
    rst_n       = 1'b1;
    advance();
    m_if.address = 32'h0000_0400;
    m_if.rd      = 1'b1;
    advance();
    s0_if.ready   = 1'b1;
    s0_if.rd_data = 32'h0BAD_CAFE;
    settle();
    check_eq("post_rst_s0_rd", s0_if.rd, 1);
    check_eq("post_rst_m_ready", m_if.ready, 1);
    check_eq("post_rst_m_rd_data", m_if.rd_data, 32'h0BAD_CAFE);
    check_eq("post_rst_m_error", m_if.error, 0);
    advance();
    idle_master();
    s0_if.ready = 1'b0;
    settle();
    check_eq("post_rst_after_m_ready", m_if.ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
